viterbi_traceback: RTL and testbench
====================================

Name: viterbi_traceback

Overview:
- Survivor-path traceback controller for the Viterbi decoder.
- Accepts one per-stage decision word per cycle from the ACS stage and stores a whole frame in the 24x2048 survivor SRAM, which it drives as the single master.
- Once the frame is stored, it traces back from the tail-terminated end state and emits one decoded bit per cycle, newest first, each with its bit index.

Parameters:
- K, 5, constraint length; NUM_STATES = 2^(K-1) = 16; legal only while NUM_STATES <= DATA_W.
- START_STATE, 0, traceback start state; the encoder is tail-terminated to this state.
- ADDR_W, 11, survivor SRAM address width; maximum frame length is 2^ADDR_W = 2048.
- DATA_W, 24, survivor SRAM word width; bits [NUM_STATES-1:0] hold decisions, upper bits are written as 0.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- dec_valid_i  in  1  decision word valid.
- dec_word_i  in  NUM_STATES  decision bits; bit s = survivor decision for state s.
- dec_last_i  in  1  marks the final stage of the frame; qualified by dec_valid_i.
- dec_ready_o  out  1  high while the block can accept decision words.
- sram_wr_en_o  out  1  survivor SRAM write enable.
- sram_rd_en_o  out  1  survivor SRAM read enable.
- sram_addr_o  out  ADDR_W  survivor SRAM address.
- sram_wdata_o  out  DATA_W  survivor SRAM write data, {zero pad, dec_word_i}.
- sram_rdata_i  in  DATA_W  survivor SRAM read data; valid exactly one cycle after rd_en, not stable in any other cycle.
- bit_valid_o  out  1  decoded bit valid.
- bit_o  out  1  decoded bit.
- bit_idx_o  out  ADDR_W  stage index of bit_o, 0 = first stage of the frame.
- frame_done_o  out  1  one-cycle pulse with the bit at index 0.
- overflow_o  out  1  one-cycle pulse when a frame is force-terminated at 2048 words.

Behaviour:
- Reset values: all outputs 0, except dec_ready_o = 1. State = FILL, wr_cnt = 0, tb_state = START_STATE.
- FILL state:
  - dec_ready_o = 1.
  - On dec_valid_i: sram_wr_en_o = 1, sram_addr_o = wr_cnt, wr_cnt increments.
  - On dec_valid_i & dec_last_i: latch len = wr_cnt + 1 (12-bit value, range 1..2048) and go to TB.
  - If wr_cnt = 2047 and dec_valid_i arrives without dec_last_i: the word is stored, treated as last, overflow_o pulses in that cycle, and the state goes to TB.
- TB state:
  - dec_ready_o = 0; dec_valid_i is ignored and dropped, with no write.
  - First TB cycle: sram_rd_en_o = 1, addr = len-1, tb_state = START_STATE.
  - Each following cycle: issue the next read at addr-1 while reads remain. Reads are back-to-back, because the address does not depend on the traceback state.
- Read-response pipeline, one cycle after each read at address a:
  - d = sram_rdata_i[tb_state].
  - Outputs: bit_valid_o = 1, bit_o = tb_state[0], bit_idx_o = a.
  - tb_state <= {d, tb_state[K-2:1]}, the predecessor state. The encoder state holds the newest input in the LSB.
- The response pipeline register tracks the issued address. Outputs are registered, so bit_valid_o and sram_rdata_i are not sampled in the same cycle.
- Latency:
  - dec_last_i is accepted at edge E.
  - First read is issued in cycle E+1.
  - First bit (idx len-1) is valid in cycle E+2.
  - L bits follow on consecutive cycles; the last bit is at E+L+1, together with frame_done_o.
  - The block returns to FILL (dec_ready_o = 1) in cycle E+L+2.
- sram_wr_en_o and sram_rd_en_o are never high in the same cycle. When both are low, sram_addr_o holds its last value.
- A frame with len = 1 issues one read, emits one bit (idx 0) and pulses frame_done_o.
- Reset mid-FILL or mid-TB: everything returns to reset values immediately. The partial frame is discarded and no further bit_valid_o appears.
- Decoded bits leave in reverse order. Reordering by bit_idx_o is the downstream block's job.

Decomposition:
- Shared package viterbi_pkg holds K, NUM_STATES, ADDR_W, DATA_W, START_STATE, the FILL/TB state encoding, and the max frame length 2^ADDR_W.
- Sub-module tb_state_update: combinational predecessor and decoded-bit logic, inputs (tb_state, rdata) and outputs (next_state, bit).
- The FSM, counters and SRAM drive stay in the top module.

Test Plan:
- Encoded frame of 8 bits: input bits 1,0,1,1,0,0,0,0 (4-zero tail), with ideal decisions from a reference encoder model, SRAM model attached → addresses 0..7 written. bit_o sequence by idx 7..0 = 0,0,0,0,1,1,0,1. frame_done_o with idx 0 at E+9.
- Single-word frame: dec_valid_i & dec_last_i in the first cycle → exactly one write, one read at addr 0, one bit at idx 0 with frame_done_o, dec_ready_o high again 3 cycles after acceptance.
- 2048 words, no dec_last_i → overflow_o pulses on the write to addr 2047. Traceback reads 2047..0; 2048 bits are emitted; no write to addr 0 is ever wrapped.
- dec_valid_i held high during TB of a 4-word frame → no sram_wr_en_o during TB. The first word after return to FILL is written at addr 0.
- rst_i asserted at the 3rd traceback bit of a 16-word frame → all outputs 0 immediately, dec_ready_o = 1. The next frame writes from addr 0 and decodes correctly.
- Throughout all tests, assert that sram_wr_en_o and sram_rd_en_o are never both high, and that bit_valid_o is never high outside TB.

Source files
------------

// File: rtl/viterbi_pkg.sv
// Shared constants and types for the Viterbi survivor-path traceback block.
`timescale 1ns/1ps
package viterbi_pkg;
    localparam int K          = 5;
    localparam int NUM_STATES = 2 ** (K - 1);
    localparam int ADDR_W     = 11;
    localparam int DATA_W     = 24;
    localparam int MAX_FRAME  = 2 ** ADDR_W;

    typedef logic [K-2:0]          tb_state_t;
    typedef logic [ADDR_W-1:0]     addr_t;
    typedef logic [NUM_STATES-1:0] dec_word_t;
    typedef logic [DATA_W-1:0]     data_t;

    // Encoder is tail-terminated into this state, so traceback starts here.
    localparam tb_state_t START_STATE = '0;

    typedef enum logic {
        FILL = 1'b0,
        TB   = 1'b1
    } tb_fsm_t;
endpackage

// File: rtl/viterbi_traceback_if.sv
// Decision stream, survivor SRAM bus and decoded-bit stream of the traceback block.
`timescale 1ns/1ps
interface viterbi_traceback_if;
    import viterbi_pkg::*;

    logic      dec_valid;
    dec_word_t dec_word;
    logic      dec_last;
    logic      dec_ready;

    logic      sram_wr_en;
    logic      sram_rd_en;
    addr_t     sram_addr;
    data_t     sram_wdata;
    data_t     sram_rdata;

    logic      bit_valid;
    logic      dec_bit;
    addr_t     bit_idx;
    logic      frame_done;
    logic      overflow;

    modport slave (
        input  dec_valid, dec_word, dec_last, sram_rdata,
        output dec_ready, sram_wr_en, sram_rd_en, sram_addr, sram_wdata,
               bit_valid, dec_bit, bit_idx, frame_done, overflow
    );

    modport master (
        output dec_valid, dec_word, dec_last, sram_rdata,
        input  dec_ready, sram_wr_en, sram_rd_en, sram_addr, sram_wdata,
               bit_valid, dec_bit, bit_idx, frame_done, overflow
    );
endinterface

// File: rtl/viterbi_traceback_tb_state_update.sv
// One traceback step: predecessor state from the stored survivor decision,
// plus the decoded bit that the predecessor stage carries in its LSB.
`timescale 1ns/1ps
module tb_state_update
    import viterbi_pkg::*;
(
    input  tb_state_t tb_state,
    input  dec_word_t rdata,
    output tb_state_t next_state,
    output logic      dec_bit
);
    assign next_state = {rdata[tb_state], tb_state[K-2:1]};
    assign dec_bit    = next_state[0];
endmodule

// File: rtl/viterbi_traceback.sv
// Survivor-path traceback controller: stores a frame of decisions, then
// traces back from START_STATE emitting one decoded bit per cycle, newest first.
//   state | meaning
//   FILL  | accepting decision words, writing survivor SRAM
//   TB    | reading survivors backwards, emitting decoded bits
`timescale 1ns/1ps
module viterbi_traceback
    import viterbi_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_i,
    viterbi_traceback_if.slave bus
);
    tb_fsm_t   state, state_nxt;
    addr_t     wr_cnt, rd_addr, addr_hold, bit_idx_q;
    logic      rd_active, wr_en, rd_en, at_max, accept_last;
    logic      bit_valid_q, bit_q, frame_done_q, cur_bit, upd_bit;
    tb_state_t tb_state, upd_state;

    tb_state_update u_update (
        .tb_state   (tb_state),
        .rdata      (bus.sram_rdata[NUM_STATES-1:0]),
        .next_state (upd_state),
        .dec_bit    (upd_bit)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state <= FILL;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            FILL:    if (accept_last) state_nxt = TB;
            TB:      if (frame_done_q) state_nxt = FILL;
            default: state_nxt = FILL;
        endcase
    end

    // Write path is combinational from dec_valid; gated by rst_i so reset forces it low at once.
    always_comb begin
        bus.dec_ready = (state == FILL);
        wr_en         = (state == FILL) && bus.dec_valid && !rst_i;
        rd_en         = (state == TB) && rd_active;
        at_max        = (wr_cnt == addr_t'(MAX_FRAME - 1));
        accept_last   = wr_en && (bus.dec_last || at_max);
        bus.overflow  = wr_en && at_max && !bus.dec_last;
        bus.sram_wr_en = wr_en;
        bus.sram_rd_en = rd_en;
        bus.sram_wdata = wr_en ? data_t'(bus.dec_word) : '0;
        if (wr_en)      bus.sram_addr = wr_cnt;
        else if (rd_en) bus.sram_addr = rd_addr;
        else            bus.sram_addr = addr_hold;
        bus.bit_valid  = bit_valid_q;
        bus.dec_bit    = bit_q;
        bus.bit_idx    = bit_idx_q;
        bus.frame_done = frame_done_q;
    end

    // With back-to-back reads the state for the stage being read is the
    // predecessor being resolved this very cycle, whose LSB is already known.
    assign cur_bit = bit_valid_q ? upd_bit : tb_state[0];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_cnt       <= '0;
            rd_addr      <= '0;
            rd_active    <= 1'b0;
            addr_hold    <= '0;
            tb_state     <= START_STATE;
            bit_valid_q  <= 1'b0;
            bit_q        <= 1'b0;
            bit_idx_q    <= '0;
            frame_done_q <= 1'b0;
        end else begin
            addr_hold <= bus.sram_addr;
            if (wr_en) wr_cnt <= accept_last ? '0 : wr_cnt + 1'b1;
            if (bit_valid_q) tb_state <= upd_state;
            if (accept_last) begin
                rd_addr   <= wr_cnt;
                rd_active <= 1'b1;
                tb_state  <= START_STATE;
            end else if (rd_en) begin
                rd_addr <= rd_addr - 1'b1;
                if (rd_addr == '0) rd_active <= 1'b0;
            end
            bit_valid_q  <= rd_en;
            frame_done_q <= rd_en && (rd_addr == '0);
            if (rd_en) begin
                bit_q     <= cur_bit;
                bit_idx_q <= rd_addr;
            end
        end
    end
endmodule

// File: tb/tb_viterbi_traceback.sv
// Directed bench for viterbi_traceback with an attached survivor SRAM model.
`timescale 1ns/1ps
module tb_viterbi_traceback;
    import viterbi_pkg::*;

    logic clk_i = 1'b0;
    logic rst_i;
    always #5 clk_i = ~clk_i;

    viterbi_traceback_if vif ();
    viterbi_traceback dut (.clk_i(clk_i), .rst_i(rst_i), .bus(vif));

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    // SRAM model: read data valid one cycle after rd_en, garbage otherwise.
    data_t mem [MAX_FRAME];
    always @(posedge clk_i) begin
        if (vif.sram_wr_en) mem[vif.sram_addr] <= vif.sram_wdata;
        vif.sram_rdata <= vif.sram_rd_en ? mem[vif.sram_addr] : data_t'($urandom);
    end

    logic      ubits [MAX_FRAME];
    dec_word_t words [MAX_FRAME];
    logic      bit_val [MAX_FRAME];

    int both_hi = 0, bv_outside = 0, wr_in_tb = 0;
    int n_wr, n_wr0, first_wr_addr, n_rd, first_rd_addr, last_rd_addr;
    int n_ovf, ovf_addr, n_bits, first_idx, prev_idx, order_err, done_cyc, n_done;

    always @(negedge clk_i) begin
        if (vif.sram_wr_en && vif.sram_rd_en) both_hi++;
        if (vif.bit_valid && vif.dec_ready) bv_outside++;
        if (vif.sram_wr_en && !vif.dec_ready) wr_in_tb++;
        if (vif.sram_wr_en) begin
            if (n_wr == 0) first_wr_addr = int'(vif.sram_addr);
            if (vif.sram_addr == '0) n_wr0++;
            n_wr++;
        end
        if (vif.sram_rd_en) begin
            if (n_rd == 0) first_rd_addr = int'(vif.sram_addr);
            last_rd_addr = int'(vif.sram_addr);
            n_rd++;
        end
        if (vif.overflow) begin
            n_ovf++;
            ovf_addr = int'(vif.sram_addr);
        end
        if (vif.bit_valid) begin
            if (n_bits == 0) first_idx = int'(vif.bit_idx);
            else if (int'(vif.bit_idx) != prev_idx - 1) order_err++;
            prev_idx = int'(vif.bit_idx);
            bit_val[vif.bit_idx] = vif.dec_bit;
            n_bits++;
        end
        if (vif.frame_done) begin
            done_cyc = cyc;
            n_done++;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_mon();
        n_wr = 0; n_wr0 = 0; first_wr_addr = -1; n_rd = 0; first_rd_addr = -1; last_rd_addr = -1;
        n_ovf = 0; ovf_addr = -1; n_bits = 0; first_idx = -1; prev_idx = 0; order_err = 0;
        done_cyc = -1; n_done = 0;
    endtask

    // Reference convolutional encoder: the survivor decision at the reached
    // state is the MSB dropped from the previous state; other bits are noise.
    function automatic void build_frame(input int n);
        tb_state_t s, prev;
        s = '0;
        for (int i = 0; i < n; i++) begin
            prev = s;
            s = {s[K-3:0], ubits[i]};
            words[i] = dec_word_t'($urandom);
            words[i][s] = prev[K-2];
        end
    endfunction

    task automatic send_frame(input int n, input bit with_last, input bit hold_valid, output int e_cnt);
        @(posedge clk_i); #1;
        for (int i = 0; i < n; i++) begin
            vif.dec_valid = 1'b1;
            vif.dec_word  = words[i];
            vif.dec_last  = with_last && (i == n - 1);
            @(posedge clk_i); #1;
        end
        e_cnt = cyc;
        vif.dec_last = 1'b0;
        if (hold_valid) vif.dec_word = 16'hA5C3;
        else begin
            vif.dec_valid = 1'b0;
            vif.dec_word  = '0;
        end
    endtask

    // Returns at the negedge of the frame_done cycle, then steps one more cycle.
    task automatic wait_done(input string tag, input int budget);
        bit got = 1'b0;
        for (int k = 0; k < budget && !got; k++) begin
            @(negedge clk_i);
            if (vif.frame_done) got = 1'b1;
        end
        check_eq({tag, "_done_seen"}, got, 1);
        check_eq({tag, "_ready_in_tb"}, vif.dec_ready, 0);
        @(negedge clk_i);
        check_eq({tag, "_ready_after"}, vif.dec_ready, 1);
    endtask

    function automatic int bit_mismatches(input int n);
        int m = 0;
        for (int i = 0; i < n; i++) if (bit_val[i] !== ubits[i]) m++;
        return m;
    endfunction

    function automatic int mem_mismatches(input int n);
        int m = 0;
        for (int i = 0; i < n; i++) if (mem[i] !== data_t'(words[i])) m++;
        return m;
    endfunction

    function automatic logic [7:0] got_byte();
        logic [7:0] v;
        for (int i = 0; i < 8; i++) v[i] = bit_val[i];
        return v;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got stall expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int e;
        int seen;
        logic [7:0] pat;
        rst_i = 1'b1;
        vif.dec_valid = 1'b0;
        vif.dec_word  = '0;
        vif.dec_last  = 1'b0;
        clear_mon();
        repeat (3) @(negedge clk_i);
        check_eq("rst_ready", vif.dec_ready, 1);
        check_eq("rst_wr_en", vif.sram_wr_en, 0);
        check_eq("rst_rd_en", vif.sram_rd_en, 0);
        check_eq("rst_addr", vif.sram_addr, 0);
        check_eq("rst_bit_valid", vif.bit_valid, 0);
        check_eq("rst_frame_done", vif.frame_done, 0);
        check_eq("rst_overflow", vif.overflow, 0);
        rst_i = 1'b0;

        // 8-bit frame, inputs 1,0,1,1 then 4-zero tail.
        pat = 8'b0000_1101;
        for (int i = 0; i < 8; i++) ubits[i] = pat[i];
        build_frame(8);
        clear_mon();
        send_frame(8, 1'b1, 1'b0, e);
        wait_done("f8", 40);
        check_eq("f8_bits", got_byte(), 8'h0D);
        check_eq("f8_n_bits", n_bits, 8);
        check_eq("f8_n_wr", n_wr, 8);
        check_eq("f8_first_idx", first_idx, 7);
        check_eq("f8_order", order_err, 0);
        check_eq("f8_latency", done_cyc - e, 8);
        check_eq("f8_mem", mem_mismatches(8), 0);

        // Single-word frame.
        ubits[0] = 1'b0;
        build_frame(1);
        clear_mon();
        send_frame(1, 1'b1, 1'b0, e);
        wait_done("f1", 20);
        check_eq("f1_n_wr", n_wr, 1);
        check_eq("f1_n_rd", n_rd, 1);
        check_eq("f1_rd_addr", first_rd_addr, 0);
        check_eq("f1_n_bits", n_bits, 1);
        check_eq("f1_bit", bit_val[0], 0);
        check_eq("f1_latency", done_cyc - e, 1);

        // 2048 words without dec_last: forced termination.
        for (int i = 0; i < MAX_FRAME; i++) ubits[i] = (i < MAX_FRAME - 4) ? 1'($urandom) : 1'b0;
        build_frame(MAX_FRAME);
        clear_mon();
        send_frame(MAX_FRAME, 1'b0, 1'b0, e);
        wait_done("ovf", 2200);
        check_eq("ovf_pulses", n_ovf, 1);
        check_eq("ovf_addr", ovf_addr, 2047);
        check_eq("ovf_n_wr", n_wr, 2048);
        check_eq("ovf_wr_addr0", n_wr0, 1);
        check_eq("ovf_n_rd", n_rd, 2048);
        check_eq("ovf_first_rd", first_rd_addr, 2047);
        check_eq("ovf_last_rd", last_rd_addr, 0);
        check_eq("ovf_n_bits", n_bits, 2048);
        check_eq("ovf_order", order_err, 0);
        check_eq("ovf_bits", bit_mismatches(MAX_FRAME), 0);
        check_eq("ovf_latency", done_cyc - e, 2048);

        // 4-word frame with dec_valid held high through traceback.
        for (int i = 0; i < 4; i++) ubits[i] = 1'b0;
        build_frame(4);
        clear_mon();
        send_frame(4, 1'b1, 1'b1, e);
        wait_done("hold", 20);
        check_eq("hold_wr_en_fill", vif.sram_wr_en, 1);
        check_eq("hold_addr_fill", vif.sram_addr, 0);
        check_eq("hold_bits", bit_mismatches(4), 0);
        @(posedge clk_i); #1;
        vif.dec_last = 1'b1;
        @(posedge clk_i); #1;
        e = cyc;
        vif.dec_valid = 1'b0;
        vif.dec_last  = 1'b0;
        vif.dec_word  = '0;
        wait_done("hold2", 20);
        check_eq("hold_n_wr", n_wr, 6);
        check_eq("hold_n_bits", n_bits, 6);
        check_eq("hold2_latency", done_cyc - e, 2);

        // Reset at the third traceback bit of a 16-word frame.
        for (int i = 0; i < 16; i++) ubits[i] = (i < 12) ? 1'($urandom) : 1'b0;
        build_frame(16);
        clear_mon();
        send_frame(16, 1'b1, 1'b0, e);
        seen = 0;
        for (int k = 0; k < 40 && seen < 3; k++) begin
            @(negedge clk_i);
            if (vif.bit_valid) seen++;
        end
        rst_i = 1'b1;
        #1;
        check_eq("mrst_seen", seen, 3);
        check_eq("mrst_bit_valid", vif.bit_valid, 0);
        check_eq("mrst_rd_en", vif.sram_rd_en, 0);
        check_eq("mrst_ready", vif.dec_ready, 1);
        check_eq("mrst_idx", vif.bit_idx, 0);
        check_eq("mrst_addr", vif.sram_addr, 0);
        repeat (2) @(negedge clk_i);
        clear_mon();
        rst_i = 1'b0;
        repeat (30) @(negedge clk_i);
        check_eq("mrst_no_bits", n_bits, 0);
        check_eq("mrst_no_rd", n_rd, 0);
        pat = 8'b0000_1011;
        for (int i = 0; i < 8; i++) ubits[i] = pat[i];
        build_frame(8);
        send_frame(8, 1'b1, 1'b0, e);
        wait_done("post", 40);
        check_eq("post_first_wr", first_wr_addr, 0);
        check_eq("post_bits", got_byte(), 8'h0B);
        check_eq("post_latency", done_cyc - e, 8);

        check_eq("never_wr_and_rd", both_hi, 0);
        check_eq("no_bit_outside_tb", bv_outside, 0);
        check_eq("no_write_in_tb", wr_in_tb, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
